instr_mem_loader: RTL and testbench

//   Writer side of the instruction memory. Receives a framed program image as a byte stream,

---
 rtl/instr_mem_loader.sv | 163 ++++++++++++++++
 tb/tb_instr_mem_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: takes a framed program image from a byte stream, assembles
// little-endian words, writes them to instruction memory and holds the core in reset meanwhile.
module instr_mem_loader #(
  parameter int         MEM_SIZE  = 1024,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        Clk_Core,
  input  logic        Rst_Core,
  input  logic [7:0]  Rx_Data,
  input  logic        Rx_Valid,
  output logic        Rx_Ready,
  output logic        Mem_Wr_En,
  output logic [31:0] Mem_Wr_Addr,
  output logic [31:0] Mem_Wr_Data,
  output logic        Core_Hold,
  output logic        Load_Done,
  output logic        Load_Error
);

  localparam int          IDX_W   = $clog2(MEM_SIZE) + 1;
  localparam logic [16:0] MAX_LEN = 17'(MEM_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_WRITE,
    ST_CHK
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               xfer;
  logic [15:0]        len;
  logic [15:0]        len_full;
  logic               len_bad;
  logic               len_zero;
  logic               last_word;
  logic [1:0]         byte_cnt;
  logic [23:0]        word_buf;
  logic [7:0]         chk_acc;
  logic [IDX_W-1:0]   word_idx;

  assign xfer      = Rx_Valid & Rx_Ready;
  assign len_full  = {Rx_Data, len[7:0]};
  assign len_bad   = {1'b0, len_full} > MAX_LEN;
  assign len_zero  = (len_full == 16'd0);
  assign last_word = ((16'(word_idx) + 16'd1) == len);

  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (xfer && (Rx_Data == SYNC_BYTE)) state_nxt = ST_LEN0;
      end
      ST_LEN0: begin
        if (xfer) state_nxt = ST_LEN1;
      end
      ST_LEN1: begin
        if (xfer) begin
          if (len_bad)       state_nxt = ST_IDLE;
          else if (len_zero) state_nxt = ST_CHK;
          else               state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer && (byte_cnt == 2'd3)) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        state_nxt = last_word ? ST_CHK : ST_DATA;
      end
      ST_CHK: begin
        if (xfer) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    Rx_Ready = (state != ST_WRITE);
  end

  // Write port registers load on the 4th byte so the strobe, address and data all
  // appear together in the WRITE cycle and then hold until the next word.
  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      Mem_Wr_En   <= 1'b0;
      Mem_Wr_Addr <= 32'd0;
      Mem_Wr_Data <= 32'd0;
      Core_Hold   <= 1'b0;
      Load_Done   <= 1'b0;
      Load_Error  <= 1'b0;
      len         <= 16'd0;
      byte_cnt    <= 2'd0;
      word_buf    <= 24'd0;
      chk_acc     <= 8'd0;
      word_idx    <= '0;
    end else begin
      Mem_Wr_En <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer && (Rx_Data == SYNC_BYTE)) begin
            Load_Done  <= 1'b0;
            Load_Error <= 1'b0;
            Core_Hold  <= 1'b1;
            chk_acc    <= 8'd0;
            word_idx   <= '0;
            byte_cnt   <= 2'd0;
          end
        end
        ST_LEN0: begin
          if (xfer) len[7:0] <= Rx_Data;
        end
        ST_LEN1: begin
          if (xfer) begin
            len[15:8] <= Rx_Data;
            if (len_bad) begin
              Load_Error <= 1'b1;
              Core_Hold  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            chk_acc  <= chk_acc ^ Rx_Data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= Rx_Data;
              2'd1: word_buf[15:8]  <= Rx_Data;
              2'd2: word_buf[23:16] <= Rx_Data;
              default: begin
                Mem_Wr_En   <= 1'b1;
                Mem_Wr_Addr <= 32'({word_idx, 2'b00});
                Mem_Wr_Data <= {Rx_Data, word_buf};
              end
            endcase
          end
        end
        ST_WRITE: begin
          word_idx <= word_idx + IDX_W'(1);
        end
        ST_CHK: begin
          if (xfer) begin
            if (Rx_Data == chk_acc) Load_Done  <= 1'b1;
            else                    Load_Error <= 1'b1;
            Core_Hold <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: random-gap byte stream driver with a frame-level reference model.
module tb_instr_mem_loader;

  localparam int         MEM_SIZE = 1024;
  localparam logic [7:0] SYNC     = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        core_hold;
  logic        load_done;
  logic        load_error;

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          ready_low = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic [31:0] frm_words[$];
  logic        hold_mid, done_mid, err_mid;

  always #5 clk = ~clk;

  instr_mem_loader #(.MEM_SIZE(MEM_SIZE), .SYNC_BYTE(SYNC)) dut (
    .Clk_Core(clk), .Rst_Core(rst), .Rx_Data(rx_data), .Rx_Valid(rx_valid),
    .Rx_Ready(rx_ready), .Mem_Wr_En(mem_wr_en), .Mem_Wr_Addr(mem_wr_addr),
    .Mem_Wr_Data(mem_wr_data), .Core_Hold(core_hold), .Load_Done(load_done),
    .Load_Error(load_error)
  );

  // Scoreboard: every write strobe must match the next expected (addr, word) pair.
  always @(negedge clk) begin
    if (rx_ready !== 1'b1) ready_low++;
    if (mem_wr_en === 1'b1) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", mem_wr_addr, mem_wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({mem_wr_addr, mem_wr_data} !== mon_exp) begin
          errors++;
          $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                   mem_wr_addr, mem_wr_data, mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] words_xor();
    logic [7:0] x = 8'd0;
    foreach (frm_words[i]) x = x ^ frm_words[i][7:0] ^ frm_words[i][15:8]
                                ^ frm_words[i][23:16] ^ frm_words[i][31:24];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap;
    int tries;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (gap) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    tries    = 0;
    while (rx_ready !== 1'b1 && tries < 8) begin
      @(negedge clk);
      tries++;
    end
    checks++;
    if (tries >= 8) begin
      errors++;
      $display("FAIL accept_timeout byte=%h waited=%0d cycles limit=8", b, tries);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input int gap_max, input logic [7:0] chk_flip);
    int n;
    logic [7:0] chk;
    n   = frm_words.size();
    chk = words_xor() ^ chk_flip;
    exp_q.delete();
    foreach (frm_words[i]) exp_q.push_back({32'(i * 4), frm_words[i]});
    wr_cnt    = 0;
    ready_low = 0;
    send_byte(SYNC, gap_max);
    send_byte(n[7:0], gap_max);
    send_byte(n[15:8], gap_max);
    hold_mid = core_hold;
    done_mid = load_done;
    err_mid  = load_error;
    foreach (frm_words[i])
      for (int b = 0; b < 4; b++) send_byte(frm_words[i][8*b +: 8], gap_max);
    send_byte(chk, gap_max);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (mem_wr_en !== 1'b0)   begin errors++; $display("FAIL rst_wr_en got=%b exp=0", mem_wr_en); end
    checks++; if (mem_wr_addr !== 32'd0) begin errors++; $display("FAIL rst_addr got=%h exp=0", mem_wr_addr); end
    checks++; if (mem_wr_data !== 32'd0) begin errors++; $display("FAIL rst_data got=%h exp=0", mem_wr_data); end
    checks++; if (core_hold !== 1'b0)   begin errors++; $display("FAIL rst_hold got=%b exp=0", core_hold); end
    checks++; if (load_done !== 1'b0)   begin errors++; $display("FAIL rst_done got=%b exp=0", load_done); end
    checks++; if (load_error !== 1'b0)  begin errors++; $display("FAIL rst_error got=%b exp=0", load_error); end
    checks++; if (rx_ready !== 1'b1)    begin errors++; $display("FAIL rst_ready got=%b exp=1", rx_ready); end
  endtask

  task automatic test_good_frame();
    frm_words = '{32'h00000013, 32'h00100093};
    run_frame(0, 8'h00);
    checks++; if (hold_mid !== 1'b1)   begin errors++; $display("FAIL good_hold_mid got=%b exp=1", hold_mid); end
    checks++; if (core_hold !== 1'b0)  begin errors++; $display("FAIL good_hold_end got=%b exp=0", core_hold); end
    checks++; if (load_done !== 1'b1)  begin errors++; $display("FAIL good_done got=%b exp=1", load_done); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL good_error got=%b exp=0", load_error); end
    checks++; if (wr_cnt !== 2)        begin errors++; $display("FAIL good_wr_cnt got=%0d exp=2", wr_cnt); end
  endtask

  task automatic test_bad_checksum();
    frm_words = '{32'h00000013, 32'h00100093};
    run_frame(0, words_xor());
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL badchk_error got=%b exp=1", load_error); end
    checks++; if (load_done !== 1'b0)  begin errors++; $display("FAIL badchk_done got=%b exp=0", load_done); end
    checks++; if (core_hold !== 1'b0)  begin errors++; $display("FAIL badchk_hold got=%b exp=0", core_hold); end
    checks++; if (wr_cnt !== 2)        begin errors++; $display("FAIL badchk_wr_cnt got=%0d exp=2", wr_cnt); end
    checks++; if (done_mid !== 1'b0)   begin errors++; $display("FAIL badchk_done_cleared got=%b exp=0", done_mid); end
  endtask

  task automatic test_empty_frame();
    frm_words.delete();
    run_frame(0, 8'h00);
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL empty_done got=%b exp=1", load_done); end
    checks++; if (err_mid !== 1'b0)   begin errors++; $display("FAIL empty_err_cleared got=%b exp=0", err_mid); end
    checks++; if (wr_cnt !== 0)       begin errors++; $display("FAIL empty_wr_cnt got=%0d exp=0", wr_cnt); end
  endtask

  task automatic test_oversize();
    exp_q.delete();
    wr_cnt = 0;
    send_byte(SYNC, 0);
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    @(negedge clk);
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL over_error got=%b exp=1", load_error); end
    checks++; if (load_done !== 1'b0)  begin errors++; $display("FAIL over_done got=%b exp=0", load_done); end
    checks++; if (core_hold !== 1'b0)  begin errors++; $display("FAIL over_hold got=%b exp=0", core_hold); end
    for (int i = 0; i < 12; i++) send_byte(8'(i * 16 + 3), 1);
    repeat (2) @(negedge clk);
    checks++; if (wr_cnt !== 0)        begin errors++; $display("FAIL over_wr_cnt got=%0d exp=0", wr_cnt); end
    checks++; if (core_hold !== 1'b0)  begin errors++; $display("FAIL over_ignored_hold got=%b exp=0", core_hold); end
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL over_sticky got=%b exp=1", load_error); end
    frm_words = '{32'hDEADBEEF};
    run_frame(0, 8'h00);
    checks++; if (load_done !== 1'b1)  begin errors++; $display("FAIL over_recover_done got=%b exp=1", load_done); end
  endtask

  task automatic test_gaps();
    send_byte(8'h00, 3);
    send_byte(8'hFF, 3);
    send_byte(8'h5A, 3);
    frm_words = '{32'h00000013, 32'h00100093};
    run_frame(4, 8'h00);
    checks++; if (wr_cnt !== 2)       begin errors++; $display("FAIL gaps_wr_cnt got=%0d exp=2", wr_cnt); end
    checks++; if (ready_low !== 2)    begin errors++; $display("FAIL gaps_ready_low got=%0d exp=2", ready_low); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL gaps_done got=%b exp=1", load_done); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bytes[9];
    bytes = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    exp_q.delete();
    exp_q.push_back({32'h0, 32'h00000013});
    wr_cnt = 0;
    foreach (bytes[i]) send_byte(bytes[i], 1);
    rst = 1'b1;
    #1;
    checks++; if (mem_wr_en !== 1'b0 || mem_wr_addr !== 32'd0 || mem_wr_data !== 32'd0)
      begin errors++; $display("FAIL midrst_port got en=%b a=%h d=%h exp 0", mem_wr_en, mem_wr_addr, mem_wr_data); end
    checks++; if (core_hold !== 1'b0 || load_done !== 1'b0 || load_error !== 1'b0)
      begin errors++; $display("FAIL midrst_flags got h=%b d=%b e=%b exp 0", core_hold, load_done, load_error); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (wr_cnt !== 1)         begin errors++; $display("FAIL midrst_wr_cnt got=%0d exp=1", wr_cnt); end
    checks++; if (exp_q.size() !== 0)   begin errors++; $display("FAIL midrst_first_word missing=%0d exp=0", exp_q.size()); end
    frm_words = '{32'h00000013, 32'h00100093};
    run_frame(2, 8'h00);
    checks++; if (load_done !== 1'b1 || wr_cnt !== 2)
      begin errors++; $display("FAIL midrst_reload got done=%b wr=%0d exp done=1 wr=2", load_done, wr_cnt); end
  endtask

  task automatic test_random_frames();
    int n;
    logic [7:0] flip;
    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(6, 1));
      frm_words.delete();
      for (int i = 0; i < n; i++) frm_words.push_back($urandom);
      if (t == 0) frm_words[0] = 32'hA5A5A5A5;
      flip = ($urandom_range(1, 0) == 1) ? 8'($urandom_range(255, 1)) : 8'h00;
      run_frame(3, flip);
      checks++; if (load_done !== (flip == 8'h00))  begin errors++; $display("FAIL rnd%0d_done got=%b exp=%b", t, load_done, flip == 8'h00); end
      checks++; if (load_error !== (flip != 8'h00)) begin errors++; $display("FAIL rnd%0d_error got=%b exp=%b", t, load_error, flip != 8'h00); end
      checks++; if (wr_cnt !== n)                   begin errors++; $display("FAIL rnd%0d_wr_cnt got=%0d exp=%0d", t, wr_cnt, n); end
      checks++; if (done_mid !== 1'b0 || err_mid !== 1'b0 || hold_mid !== 1'b1)
        begin errors++; $display("FAIL rnd%0d_mid got d=%b e=%b h=%b exp 0 0 1", t, done_mid, err_mid, hold_mid); end
    end
  endtask

  task automatic test_max_length();
    frm_words.delete();
    for (int i = 0; i < MEM_SIZE; i++) frm_words.push_back($urandom);
    run_frame(0, 8'h00);
    checks++; if (wr_cnt !== MEM_SIZE)  begin errors++; $display("FAIL max_wr_cnt got=%0d exp=%0d", wr_cnt, MEM_SIZE); end
    checks++; if (load_done !== 1'b1)   begin errors++; $display("FAIL max_done got=%b exp=1", load_done); end
    checks++; if (mem_wr_addr !== 32'(4 * (MEM_SIZE - 1)))
      begin errors++; $display("FAIL max_last_addr got=%h exp=%h", mem_wr_addr, 32'(4 * (MEM_SIZE - 1))); end
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_good_frame();
    test_bad_checksum();
    test_empty_frame();
    test_oversize();
    test_gaps();
    test_reset_mid();
    test_random_frames();
    test_max_length();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
